// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: bus layout, exception codes and sizes.
// The memory stage packs MEM_to_WB_bus with the same struct and offsets.
package wb_stage_pkg;

  localparam int          BUS_W   = 207;
  localparam int          CNT_W   = 64;
  localparam logic [13:0] TID_NUM = 14'h040;

  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  // LSB offset of each bus field
  localparam int OFF_RESULT  = 0;
  localparam int OFF_DEST    = 32;
  localparam int OFF_GR_WE   = 37;
  localparam int OFF_PC      = 38;
  localparam int OFF_CSR_NUM = 70;
  localparam int OFF_CSRXCHG = 84;
  localparam int OFF_CSRWR   = 85;
  localparam int OFF_CSRRD   = 86;
  localparam int OFF_ERTN    = 87;
  localparam int OFF_SYSCALL = 88;
  localparam int OFF_RKD     = 89;
  localparam int OFF_RJ      = 121;
  localparam int OFF_EX_CODE = 153;
  localparam int OFF_RDCNTVH = 168;
  localparam int OFF_RDCNTVL = 169;
  localparam int OFF_RDCNTID = 170;
  localparam int OFF_BRK     = 171;
  localparam int OFF_BADDR   = 172;
  localparam int OFF_ALE     = 204;
  localparam int OFF_INE     = 205;
  localparam int OFF_ADEF    = 206;

  typedef struct packed {
    logic        adef;
    logic        ine;
    logic        ale;
    logic [31:0] baddr;
    logic        brk;
    logic        rdcntid;
    logic        rdcntvl;
    logic        rdcntvh;
    logic [14:0] ex_code;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic        syscall;
    logic        ertn;
    logic        csrrd;
    logic        csrwr;
    logic        csrxchg;
    logic [13:0] csr_num;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } mem_wb_bus_t;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-to-write-back handshake. Valid/ready: a beat transfers on a rising clk edge
// where MEM_to_WB_valid and WB_allowin are both high; the bus is held stable while valid is high.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic             MEM_to_WB_valid;
  logic [BUS_W-1:0] MEM_to_WB_bus;
  logic             WB_allowin;

  modport master (output MEM_to_WB_valid, output MEM_to_WB_bus, input WB_allowin);
  modport slave  (input MEM_to_WB_valid, input MEM_to_WB_bus, output WB_allowin);
endinterface

// File: rtl/wb_stage_stable_counter.sv
// Free-running stable counter read by rdcntvl.w / rdcntvh.w; wraps from all-ones to zero.
module stable_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits one instruction per cycle, raises exceptions/ertn, drives exec_flush.
// Optional stable counter is built when STABLE_COUNTER_EN is defined.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  wb_stage_if.slave     mem_wb,
  output logic          exec_flush,
  output logic          ertn_flush,
  output logic          wb_ex,
  output logic [5:0]    wb_ecode,
  output logic [8:0]    wb_esubcode,
  output logic [31:0]   wb_pc,
  output logic [31:0]   wb_vaddr,
  output logic          csr_re,
  output logic [13:0]   csr_num,
  input  logic [31:0]   csr_rvalue,
  output logic          csr_we,
  output logic [31:0]   csr_wmask,
  output logic [31:0]   csr_wvalue,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  output logic [38:0]   WB_fwd,
  output logic [31:0]   debug_wb_pc,
  output logic [3:0]    debug_wb_rf_we,
  output logic [4:0]    debug_wb_rf_wnum,
  output logic [31:0]   debug_wb_rf_wdata
);
  logic             ready_go;
  logic             wb_allowin;
  logic             wb_valid_q, wb_valid_d;
  mem_wb_bus_t      bus_q, bus_d;
  logic [CNT_W-1:0] cnt;
  logic             ex;
  logic             csr_op;

  assign ready_go          = 1'b1;
  assign wb_allowin        = !wb_valid_q | ready_go;
  assign mem_wb.WB_allowin = wb_allowin;

`ifdef STABLE_COUNTER_EN
  stable_counter #(.CNT_W(CNT_W)) u_stable_counter (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt)
  );
`else
  assign cnt = '0;
`endif

  // A committing exception/ertn drops whatever beat arrives alongside it.
  always_comb begin
    wb_valid_d = wb_valid_q;
    if (exec_flush)      wb_valid_d = 1'b0;
    else if (wb_allowin) wb_valid_d = mem_wb.MEM_to_WB_valid;
    bus_d = bus_q;
    if (wb_allowin && mem_wb.MEM_to_WB_valid) bus_d = mem_wb.MEM_to_WB_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) wb_valid_q <= 1'b0;
    else       wb_valid_q <= wb_valid_d;
  end

  always_ff @(posedge clk) bus_q <= bus_d;

  always_comb begin
    ex          = bus_q.adef | bus_q.ine | bus_q.ale | bus_q.syscall | bus_q.brk;
    csr_op      = bus_q.csrrd | bus_q.csrwr | bus_q.csrxchg | bus_q.rdcntid;

    wb_ex       = wb_valid_q & ex;
    ertn_flush  = wb_valid_q & bus_q.ertn & ~ex;
    exec_flush  = wb_ex | ertn_flush;
    wb_ecode    = bus_q.ex_code[5:0];
    wb_esubcode = bus_q.ex_code[14:6];
    wb_pc       = bus_q.pc;
    wb_vaddr    = bus_q.adef ? bus_q.pc : bus_q.baddr;

    csr_re      = wb_valid_q & csr_op;
    csr_num     = bus_q.rdcntid ? TID_NUM : bus_q.csr_num;
    csr_we      = wb_valid_q & (bus_q.csrwr | bus_q.csrxchg) & ~ex;
    csr_wmask   = bus_q.csrxchg ? bus_q.rj : 32'hFFFF_FFFF;
    csr_wvalue  = bus_q.rkd;

    rf_wdata = bus_q.result;
    if (csr_op)             rf_wdata = csr_rvalue;
    else if (bus_q.rdcntvl) rf_wdata = cnt[31:0];
    else if (bus_q.rdcntvh) rf_wdata = cnt[63:32];
    rf_we    = wb_valid_q & bus_q.gr_we & ~ex;
    rf_waddr = bus_q.dest;

    WB_fwd = {wb_valid_q & bus_q.gr_we,
              wb_valid_q & (csr_op | bus_q.ertn | ex),
              bus_q.dest, rf_wdata};

    debug_wb_pc       = bus_q.pc;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = bus_q.dest;
    debug_wb_rf_wdata = rf_wdata;
  end
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized stream against a reference model.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] csr_rvalue = '0;
  logic        exec_flush, ertn_flush, wb_ex, csr_re, csr_we, rf_we;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, csr_wmask, csr_wvalue, rf_wdata;
  logic [13:0] csr_num;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [38:0] WB_fwd;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;
  logic [63:0] tb_cnt = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Reference for the stable counter: cycles elapsed since reset was released.
  always @(posedge clk) tb_cnt <= reset ? 64'd0 : tb_cnt + 64'd1;

  wb_stage_if mem_wb ();

  wb_stage dut (
    .clk(clk), .reset(reset), .mem_wb(mem_wb),
    .exec_flush(exec_flush), .ertn_flush(ertn_flush), .wb_ex(wb_ex),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .WB_fwd(WB_fwd), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic drive(input mem_wb_bus_t b, input logic v);
    mem_wb.MEM_to_WB_bus   = b;
    mem_wb.MEM_to_WB_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_cnt();
`ifdef STABLE_COUNTER_EN
    return tb_cnt;
`else
    return 64'd0;
`endif
  endfunction

  function automatic mem_wb_bus_t rand_beat();
    mem_wb_bus_t b;
    b = '0;
    b.adef    = ($urandom_range(0, 15) == 0);
    b.ine     = ($urandom_range(0, 15) == 0);
    b.ale     = ($urandom_range(0, 15) == 0);
    b.syscall = ($urandom_range(0, 15) == 0);
    b.brk     = ($urandom_range(0, 15) == 0);
    b.ertn    = ($urandom_range(0, 7) == 0);
    b.csrrd   = ($urandom_range(0, 7) == 0);
    b.csrwr   = ($urandom_range(0, 7) == 0);
    b.csrxchg = ($urandom_range(0, 7) == 0);
    b.rdcntid = ($urandom_range(0, 9) == 0);
    b.rdcntvl = ($urandom_range(0, 7) == 0);
    b.rdcntvh = ($urandom_range(0, 7) == 0);
    b.gr_we   = ($urandom_range(0, 3) != 0);
    b.baddr   = $urandom;
    b.ex_code = 15'($urandom);
    b.rj      = $urandom;
    b.rkd     = $urandom;
    b.csr_num = 14'($urandom);
    b.pc      = $urandom;
    b.dest    = 5'($urandom);
    b.result  = $urandom;
    return b;
  endfunction

  task automatic test_reset();
    drive('0, 1'b0);
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({wb_ex, ertn_flush, exec_flush, csr_re, csr_we, rf_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {wb_ex, ertn_flush, exec_flush, csr_re, csr_we, rf_we});
    end
    checks++;
    if (WB_fwd[38:37] !== 2'b00 || debug_wb_rf_we !== 4'h0) begin
      errors++;
      $display("FAIL reset_fwd: fwd=%b rf_we_dbg=%h expected 00/0", WB_fwd[38:37], debug_wb_rf_we);
    end
    checks++;
    if (mem_wb.WB_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_allowin: got %b expected 1", mem_wb.WB_allowin);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu();
    mem_wb_bus_t b = '0;
    b.gr_we = 1'b1; b.dest = 5'd5; b.result = 32'h1234; b.pc = 32'h1c00_0000;
    drive(b, 1'b1);
    step();
    drive('0, 1'b0);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL alu_write: we=%b addr=%0d data=%h expected 1/5/00001234", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (debug_wb_rf_we !== 4'hF || debug_wb_pc !== 32'h1c00_0000 || exec_flush !== 1'b0) begin
      errors++;
      $display("FAIL alu_trace: dbg_we=%h pc=%h flush=%b expected F/1c000000/0",
               debug_wb_rf_we, debug_wb_pc, exec_flush);
    end
    step();
  endtask

  task automatic test_csrxchg();
    mem_wb_bus_t b = '0;
    b.csrxchg = 1'b1; b.csr_num = 14'h0; b.rj = 32'h0000_00FF; b.rkd = 32'hA5;
    b.gr_we = 1'b1; b.dest = 5'd3;
    csr_rvalue = 32'h8;
    drive(b, 1'b1);
    step();
    drive('0, 1'b0);
    checks++;
    if (csr_we !== 1'b1 || csr_re !== 1'b1 || csr_num !== 14'h0) begin
      errors++;
      $display("FAIL csrxchg_strobe: we=%b re=%b num=%h expected 1/1/0000", csr_we, csr_re, csr_num);
    end
    checks++;
    if (csr_wmask !== 32'hFF || csr_wvalue !== 32'hA5 || rf_wdata !== 32'h8) begin
      errors++;
      $display("FAIL csrxchg_data: mask=%h wval=%h rfd=%h expected ff/a5/8", csr_wmask, csr_wvalue, rf_wdata);
    end
    step();
  endtask

  task automatic test_ale();
    mem_wb_bus_t b = '0;
    mem_wb_bus_t n = '0;
    b.ale = 1'b1; b.baddr = 32'h1c00_0003; b.ex_code = 15'h09; b.gr_we = 1'b1; b.dest = 5'd7;
    n.gr_we = 1'b1; n.dest = 5'd9; n.result = 32'hDEAD;
    drive(b, 1'b1);
    step();
    drive(n, 1'b1);
    checks++;
    if (wb_ex !== 1'b1 || exec_flush !== 1'b1 || wb_vaddr !== 32'h1c00_0003 || wb_ecode !== ECODE_ALE) begin
      errors++;
      $display("FAIL ale_raise: ex=%b flush=%b vaddr=%h ecode=%h expected 1/1/1c000003/09",
               wb_ex, exec_flush, wb_vaddr, wb_ecode);
    end
    checks++;
    if (rf_we !== 1'b0 || csr_we !== 1'b0 || WB_fwd[37] !== 1'b1) begin
      errors++;
      $display("FAIL ale_suppress: rf_we=%b csr_we=%b hazard=%b expected 0/0/1", rf_we, csr_we, WB_fwd[37]);
    end
    step();
    drive('0, 1'b0);
    checks++;
    if (WB_fwd[38] !== 1'b0 || rf_we !== 1'b0 || exec_flush !== 1'b0) begin
      errors++;
      $display("FAIL ale_drop: valid_we=%b rf_we=%b flush=%b expected 0/0/0", WB_fwd[38], rf_we, exec_flush);
    end
    step();
  endtask

  task automatic test_ertn();
    mem_wb_bus_t b = '0;
    b.ertn = 1'b1;
    drive(b, 1'b1);
    step();
    drive('0, 1'b0);
    checks++;
    if (ertn_flush !== 1'b1 || exec_flush !== 1'b1 || wb_ex !== 1'b0) begin
      errors++;
      $display("FAIL ertn: ertn=%b flush=%b ex=%b expected 1/1/0", ertn_flush, exec_flush, wb_ex);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      mem_wb_bus_t b = '0;
      b.gr_we = 1'b1; b.dest = 5'(i + 1); b.result = $urandom;
      drive(b, 1'b1);
      checks++;
      if (mem_wb.WB_allowin !== 1'b1) begin
        errors++;
        $display("FAIL b2b_allowin[%0d]: got %b expected 1", i, mem_wb.WB_allowin);
      end
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== b.dest || rf_wdata !== b.result) begin
        errors++;
        $display("FAIL b2b_commit[%0d]: we=%b addr=%0d data=%h expected 1/%0d/%h",
                 i, rf_we, rf_waddr, rf_wdata, b.dest, b.result);
      end
    end
    drive('0, 1'b0);
    step();
  endtask

  task automatic test_counter();
    mem_wb_bus_t b = '0;
    logic [63:0] exp_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (100) step();
    b.rdcntvl = 1'b1; b.gr_we = 1'b1; b.dest = 5'd4;
    drive(b, 1'b1);
    step();
    exp_cnt = model_cnt();
    checks++;
`ifdef STABLE_COUNTER_EN
    if (rf_wdata !== exp_cnt[31:0] && rf_wdata !== exp_cnt[31:0] - 32'd1 && rf_wdata !== exp_cnt[31:0] + 32'd1) begin
`else
    if (rf_wdata !== 32'h0) begin
`endif
      errors++;
      $display("FAIL counter_low: got %h expected %h", rf_wdata, exp_cnt[31:0]);
    end
    b.rdcntvl = 1'b0; b.rdcntvh = 1'b1;
    drive(b, 1'b1);
    step();
    drive('0, 1'b0);
    exp_cnt = model_cnt();
    checks++;
    if (rf_wdata !== exp_cnt[63:32]) begin
      errors++;
      $display("FAIL counter_high: got %h expected %h", rf_wdata, exp_cnt[63:32]);
    end
    step();
  endtask

  task automatic test_random();
    logic [BUS_W-1:0] exp_q[$];
    mem_wb_bus_t      cb, nb;
    logic             cv, in_v, flush_now, ex, csr_op;
    logic [5:0]       exp_strobes;
    logic [31:0]      exp_wdata;
    logic [63:0]      c;
    drive('0, 1'b0);
    step();
    flush_now = 1'b0;
    for (int i = 0; i < 400; i++) begin
      nb   = rand_beat();
      in_v = ($urandom_range(0, 3) != 0);
      drive(nb, in_v);
      if (in_v && !flush_now) exp_q.push_back(nb);
      step();
      csr_rvalue = $urandom;
      #1;
      cv = (exp_q.size() != 0);
      cb = cv ? mem_wb_bus_t'(exp_q.pop_front()) : '0;
      ex     = cb.adef || cb.ine || cb.ale || cb.syscall || cb.brk;
      csr_op = cb.csrrd || cb.csrwr || cb.csrxchg || cb.rdcntid;
      c      = model_cnt();
      if (csr_op)          exp_wdata = csr_rvalue;
      else if (cb.rdcntvl) exp_wdata = c[31:0];
      else if (cb.rdcntvh) exp_wdata = c[63:32];
      else                 exp_wdata = cb.result;
      exp_strobes = {cv && ex, cv && cb.ertn && !ex, cv && (ex || cb.ertn),
                     cv && csr_op, cv && (cb.csrwr || cb.csrxchg) && !ex, cv && cb.gr_we && !ex};
      checks++;
      if ({wb_ex, ertn_flush, exec_flush, csr_re, csr_we, rf_we} !== exp_strobes) begin
        errors++;
        $display("FAIL rand_strobes[%0d]: got %b expected %b", i,
                 {wb_ex, ertn_flush, exec_flush, csr_re, csr_we, rf_we}, exp_strobes);
      end
      if (cv) begin
        checks++;
        if (WB_fwd !== {cb.gr_we, csr_op || cb.ertn || ex, cb.dest, exp_wdata}) begin
          errors++;
          $display("FAIL rand_fwd[%0d]: got %h expected %h", i, WB_fwd,
                   {cb.gr_we, csr_op || cb.ertn || ex, cb.dest, exp_wdata});
        end
        checks++;
        if (wb_vaddr !== (cb.adef ? cb.pc : cb.baddr) || {wb_esubcode, wb_ecode} !== cb.ex_code
            || wb_pc !== cb.pc) begin
          errors++;
          $display("FAIL rand_exc[%0d]: vaddr=%h code=%h pc=%h expected %h/%h/%h", i, wb_vaddr,
                   {wb_esubcode, wb_ecode}, wb_pc, cb.adef ? cb.pc : cb.baddr, cb.ex_code, cb.pc);
        end
        checks++;
        if (csr_num !== (cb.rdcntid ? 14'h040 : cb.csr_num) || csr_wvalue !== cb.rkd
            || csr_wmask !== (cb.csrxchg ? cb.rj : 32'hFFFF_FFFF)) begin
          errors++;
          $display("FAIL rand_csr[%0d]: num=%h wval=%h mask=%h", i, csr_num, csr_wvalue, csr_wmask);
        end
        checks++;
        if (rf_waddr !== cb.dest || debug_wb_rf_wnum !== cb.dest || debug_wb_rf_wdata !== exp_wdata
            || debug_wb_rf_we !== {4{exp_strobes[0]}} || debug_wb_pc !== cb.pc) begin
          errors++;
          $display("FAIL rand_trace[%0d]: addr=%0d data=%h we=%h expected %0d/%h/%h", i,
                   rf_waddr, debug_wb_rf_wdata, debug_wb_rf_we, cb.dest, exp_wdata, {4{exp_strobes[0]}});
        end
      end else begin
        checks++;
        if (WB_fwd[38:37] !== 2'b00) begin
          errors++;
          $display("FAIL rand_idle_fwd[%0d]: got %b expected 00", i, WB_fwd[38:37]);
        end
      end
      flush_now = exp_strobes[3];
    end
    drive('0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    mem_wb_bus_t b = '0;
    mem_wb_bus_t n = '0;
    b.ale = 1'b1; b.gr_we = 1'b1;
    n.gr_we = 1'b1; n.csrwr = 1'b1; n.dest = 5'd2;
    drive(b, 1'b1);
    step();
    checks++;
    if (exec_flush !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: flush=%b expected 1", exec_flush);
    end
    reset = 1'b1;
    drive(n, 1'b1);
    step();
    checks++;
    if ({wb_ex, ertn_flush, exec_flush, csr_re, csr_we, rf_we} !== 6'b0 || WB_fwd[38:37] !== 2'b00) begin
      errors++;
      $display("FAIL midreset_post: strobes=%b fwd=%b expected 000000/00",
               {wb_ex, ertn_flush, exec_flush, csr_re, csr_we, rf_we}, WB_fwd[38:37]);
    end
    reset = 1'b0;
    drive('0, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_csrxchg();
    test_ale();
    test_ertn();
    test_back_to_back();
    test_counter();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
